adc_sequencer: RTL and testbench
================================

Name: adc_sequencer

Overview:
- Schedules the monitor ADC: steps the analogue mux through the enabled channels, waits a programmable settle time, starts a conversion and waits for completion.
- Each result is presented as a one-cycle adc_result/adc_channel/adc_strb beat to the value storage ring buffer.
- Channels are always issued in strictly ascending order, so a decrease in channel number marks a completed sweep to downstream logic.
- Configured through a 16-bit Wishbone slave on the monitor bus.

Parameters:
- TIMEOUT, 1000, max wb_clk_i cycles to wait for adc_done after adc_start before the channel is abandoned (16-bit counter).
- SETTLE_RST, 16, reset value of the settle register (cycles).
- MASK_RST, 32'hFFFF_FFFF, reset value of the channel enable mask.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- wb_cyc_i  in  1  Wishbone cycle
- wb_stb_i  in  1  Wishbone strobe
- wb_we_i  in  1  Wishbone write enable
- wb_adr_i  in  16  register offset
- wb_dat_i  in  16  write data
- wb_dat_o  out  16  read data
- wb_ack_o  out  1  Wishbone acknowledge
- adc_mux_sel  out  5  analogue mux channel select
- adc_start  out  1  conversion start pulse
- adc_done  in  1  conversion complete, 1-cycle pulse
- adc_data  in  12  conversion result, valid with adc_done
- adc_result  out  12  result to storage
- adc_channel  out  5  channel of adc_result
- adc_strb  out  1  result valid, 1-cycle pulse

Behaviour:
- Clock and reset: one clock, wb_clk_i; reset wb_rst_i is synchronous, active-high.
- Reset values: all outputs 0; CTRL.enable=0; MASK=MASK_RST; SETTLE=SETTLE_RST; ERRCNT=0; FSM=IDLE; current channel=31, so the first sweep starts at the lowest enabled channel.
- Registers (offsets):
  - 0 CTRL: bit0 enable (R/W).
  - 1 MASK_LO: enable bits for ch15..0.
  - 2 MASK_HI: enable bits for ch31..16.
  - 3 SETTLE: bits 7:0, R/W.
  - 4 STATUS (RO): bit0 = FSM not IDLE; bits 12:8 = current channel.
  - 5 ERRCNT: timeout count, saturates at 16'hFFFF; any write clears it.
  - Other offsets: reads return 0, writes are ignored, ack is still given.
- Wishbone:
  - A request (cyc & stb & ~wb_ack_o) is acked in the following cycle with a single-cycle wb_ack_o pulse.
  - Read data is valid while ack is high.
  - Write side effects become visible in the cycle after ack.
- FSM: IDLE -> SELECT -> SETTLE -> CONVERT -> STROBE -> SELECT ...
  - IDLE: outputs quiet. Moves to SELECT when enable=1.
  - SELECT (1 cycle): next channel = lowest enabled channel greater than current, else lowest enabled channel overall (wrap). Latch it into current channel and drive adc_mux_sel. If MASK==0, stay in SELECT and emit no strobes.
  - SETTLE: count SETTLE cycles with the mux stable. SETTLE=0 goes to CONVERT the next cycle.
  - CONVERT: adc_start high for exactly the first cycle. adc_done is sampled from the following cycle onward.
    - On adc_done: capture adc_data, go to STROBE.
    - If TIMEOUT cycles elapse with no adc_done: ERRCNT+1 (saturating), return to SELECT without a strobe.
  - STROBE (1 cycle): adc_strb=1, adc_channel=current channel, adc_result=captured data.
  - adc_result/adc_channel hold their values until the next strobe.
- Ordering: a single enabled channel produces repeated equal channel numbers, so no sweep boundary is seen downstream. This is acceptable but is documented for users.
- MASK writes take effect at the next SELECT. The current conversion completes on its old channel.
- enable cleared: from any state, go to IDLE next cycle.
  - adc_start deasserts and any pending result is discarded (no strobe).
  - Current channel is reset to 31.
  - A late adc_done while IDLE is ignored.
- adc_done outside CONVERT is ignored.
- wb_rst_i mid-conversion: returns to reset values immediately; no strobe.

Test Plan:
- Reset, enable=1, MASK=0x0000_0005, SETTLE=2, ADC model answers 10 cycles after start with data=ch*16 -> strobes in order ch0 (0x000), ch2 (0x020), ch0, ch2. adc_start follows SELECT by 3 cycles.
- MASK=0x8000_0001 -> channel sequence 0, 31, 0, 31. Each strobe 1 cycle wide; no strobe on a disabled channel.
- ADC model never asserts done on ch3, MASK=0x0000_000C, TIMEOUT=1000 -> ch3 abandoned after 1000 cycles, ERRCNT=1, sequence continues to ch2 with no ch3 strobe. Write ERRCNT -> reads 0.
- Clear enable during CONVERT, then ADC asserts done -> no strobe, STATUS bit0=0 next cycle. Re-enable -> sweep restarts at the lowest enabled channel.
- Write MASK_LO=0 and MASK_HI=0 while enabled -> no adc_start and no strobes for 10000 cycles. Restore MASK_LO=0x0001 -> ch0 conversions resume.
- Wishbone: read of offset 3 after reset -> 16; read of offset 7 -> 0. Every access produces exactly one ack pulse one cycle after stb; a back-to-back stb is not acked twice.

Source files
------------

// File: rtl/adc_sequencer.sv
// Monitor ADC scheduler: walks the enabled mux channels in ascending order, settles,
// converts, and hands each result to storage as a one-cycle strobe. Wishbone-configured.
module adc_sequencer #(
  parameter int          TIMEOUT    = 1000,
  parameter int          SETTLE_RST = 16,
  parameter logic [31:0] MASK_RST   = 32'hFFFF_FFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [4:0]  adc_mux_sel,
  output logic        adc_start,
  input  logic        adc_done,
  input  logic [11:0] adc_data,
  output logic [11:0] adc_result,
  output logic [4:0]  adc_channel,
  output logic        adc_strb
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SETTLE,
    S_CONVERT,
    S_STROBE
  } state_t;

  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [4:0]  CH_RESET = 5'd31;

  state_t      state_q;
  logic        enable_q;
  logic [31:0] mask_q;
  logic [7:0]  settle_q;
  logic [15:0] errcnt_q;

  logic        ack_q;
  logic [15:0] dat_q;
  logic        wr_pend_q;
  logic [15:0] wr_adr_q;
  logic [15:0] wr_dat_q;

  logic [4:0]  cur_ch_q;
  logic [4:0]  mux_q;
  logic        start_q;
  logic        strb_q;
  logic [11:0] result_q;
  logic [4:0]  channel_q;
  logic [7:0]  settle_cnt_q;
  logic [15:0] to_cnt_q;

  logic        wb_req;
  logic        wr_commit;
  logic [15:0] rd_d;
  logic        busy;
  logic [4:0]  above_ch;
  logic [4:0]  wrap_ch;
  logic        above_vld;
  logic [4:0]  next_ch;
  logic        done_seen;
  logic        to_expire;
  logic        timeout_hit;

  assign wb_req    = wb_cyc_i & wb_stb_i & ~ack_q;
  // Writes are applied as ack drops, so their effect shows the cycle after ack.
  assign wr_commit = ack_q & wr_pend_q;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    rd_d = '0;
    case (wb_adr_i)
      16'd0:   rd_d = {15'b0, enable_q};
      16'd1:   rd_d = mask_q[15:0];
      16'd2:   rd_d = mask_q[31:16];
      16'd3:   rd_d = {8'b0, settle_q};
      16'd4:   rd_d = {3'b0, cur_ch_q, 7'b0, busy};
      16'd5:   rd_d = errcnt_q;
      default: rd_d = '0;
    endcase
  end

  // Lowest enabled channel above the current one, falling back to the lowest overall.
  always_comb begin
    above_ch  = '0;
    wrap_ch   = '0;
    above_vld = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (mask_q[i]) begin
        wrap_ch = 5'(i);
        if (i > int'(cur_ch_q)) begin
          above_ch  = 5'(i);
          above_vld = 1'b1;
        end
      end
    end
    next_ch = above_vld ? above_ch : wrap_ch;
  end

  // The start cycle itself never samples adc_done.
  assign done_seen   = (state_q == S_CONVERT) & ~start_q & adc_done;
  assign to_expire   = (state_q == S_CONVERT) & ~done_seen & (to_cnt_q == TO_LAST);
  assign timeout_hit = enable_q & to_expire;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      wr_pend_q <= 1'b0;
      wr_adr_q  <= '0;
      wr_dat_q  <= '0;
    end else begin
      ack_q     <= wb_req;
      dat_q     <= wb_req ? rd_d : '0;
      wr_pend_q <= wb_req & wb_we_i;
      if (wb_req) begin
        wr_adr_q <= wb_adr_i;
        wr_dat_q <= wb_dat_i;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      enable_q <= 1'b0;
      mask_q   <= MASK_RST;
      settle_q <= 8'(SETTLE_RST);
      errcnt_q <= '0;
    end else begin
      if (wr_commit && wr_adr_q == 16'd5) begin
        errcnt_q <= '0;
      end else if (timeout_hit && errcnt_q != 16'hFFFF) begin
        errcnt_q <= errcnt_q + 16'd1;
      end
      if (wr_commit) begin
        case (wr_adr_q)
          16'd0:   enable_q       <= wr_dat_q[0];
          16'd1:   mask_q[15:0]   <= wr_dat_q;
          16'd2:   mask_q[31:16]  <= wr_dat_q;
          16'd3:   settle_q       <= wr_dat_q[7:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      cur_ch_q     <= CH_RESET;
      mux_q        <= '0;
      start_q      <= 1'b0;
      strb_q       <= 1'b0;
      result_q     <= '0;
      channel_q    <= '0;
      settle_cnt_q <= '0;
      to_cnt_q     <= '0;
    end else if (!enable_q) begin
      // Disabling abandons any conversion in flight; a late adc_done is ignored.
      state_q  <= S_IDLE;
      cur_ch_q <= CH_RESET;
      mux_q    <= '0;
      start_q  <= 1'b0;
      strb_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_SELECT;
        end
        S_SELECT: begin
          if (mask_q != '0) begin
            cur_ch_q <= next_ch;
            mux_q    <= next_ch;
            to_cnt_q <= '0;
            if (settle_q == '0) begin
              state_q <= S_CONVERT;
              start_q <= 1'b1;
            end else begin
              state_q      <= S_SETTLE;
              settle_cnt_q <= settle_q - 8'd1;
            end
          end
        end
        S_SETTLE: begin
          if (settle_cnt_q == '0) begin
            state_q <= S_CONVERT;
            start_q <= 1'b1;
          end else begin
            settle_cnt_q <= settle_cnt_q - 8'd1;
          end
        end
        S_CONVERT: begin
          start_q <= 1'b0;
          if (done_seen) begin
            result_q  <= adc_data;
            channel_q <= cur_ch_q;
            strb_q    <= 1'b1;
            state_q   <= S_STROBE;
          end else if (to_expire) begin
            state_q <= S_SELECT;
          end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
          end
        end
        S_STROBE: begin
          strb_q  <= 1'b0;
          state_q <= S_SELECT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = dat_q;
  assign adc_mux_sel = mux_q;
  assign adc_start   = start_q;
  assign adc_strb    = strb_q;
  assign adc_result  = result_q;
  assign adc_channel = channel_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer: Wishbone register access, sweep order,
// timeout handling, disable/reset mid-conversion, and the empty-mask stall.
module tb_adc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [15:0] adr, wdat;
  logic [15:0] rdat;
  logic        ack;
  logic [4:0]  mux_sel;
  logic        adc_start;
  logic        adc_done;
  logic [11:0] adc_data;
  logic [11:0] adc_result;
  logic [4:0]  adc_channel;
  logic        adc_strb;

  int total = 0;
  int bad   = 0;

  adc_sequencer dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wb_cyc_i    (cyc),
    .wb_stb_i    (stb),
    .wb_we_i     (we),
    .wb_adr_i    (adr),
    .wb_dat_i    (wdat),
    .wb_dat_o    (rdat),
    .wb_ack_o    (ack),
    .adc_mux_sel (mux_sel),
    .adc_start   (adc_start),
    .adc_done    (adc_done),
    .adc_data    (adc_data),
    .adc_result  (adc_result),
    .adc_channel (adc_channel),
    .adc_strb    (adc_strb)
  );

  always #5 clk = ~clk;

  // ADC model: done 10 cycles after start, data = ch*16; dead_ch never answers.
  int          dead_ch = -1;
  int          cd = 0;
  logic [11:0] pend_dat;
  always @(negedge clk) begin
    adc_done = 1'b0;
    if (rst) begin
      cd       = 0;
      adc_data = '0;
    end else if (adc_start) begin
      cd       = (int'(mux_sel) == dead_ch) ? 0 : 10;
      pend_dat = {3'b0, mux_sel, 4'b0};
    end else if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) begin
        adc_done = 1'b1;
        adc_data = pend_dat;
      end
    end
  end

  int         cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic [4:0]  ch_q[$];
  logic [11:0] res_q[$];
  int          gap_q[$];
  int          starts = 0;
  int          dbl = 0;
  int          last_strb = 0;
  bit          have_strb = 0;
  bit          prev_strb = 0;
  always @(negedge clk) begin
    if (adc_strb) begin
      ch_q.push_back(adc_channel);
      res_q.push_back(adc_result);
      if (prev_strb) dbl = dbl + 1;
      last_strb = cyc_n;
      have_strb = 1;
    end
    if (adc_start) begin
      starts = starts + 1;
      if (have_strb) gap_q.push_back(cyc_n - last_strb);
    end
    prev_strb = adc_strb;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = a; wdat = d;
    @(negedge clk);
    chk("wr_ack", 32'(ack), 1);
    cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    chk("wr_ack_single", 32'(ack), 0);
  endtask

  task automatic wb_rd(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = a;
    @(negedge clk);
    chk("rd_ack", 32'(ack), 1);
    d = rdat;
    cyc = 0; stb = 0;
    @(negedge clk);
    chk("rd_ack_single", 32'(ack), 0);
  endtask

  task automatic wait_strb(input int target, input int budget, input string tag);
    for (int k = 0; k < budget && ch_q.size() < target; k++) @(negedge clk);
    @(negedge clk);
    chk(tag, 32'(ch_q.size() >= target), 1);
  endtask

  task automatic wait_start(input int target, input int budget, input string tag);
    for (int k = 0; k < budget && starts < target; k++) @(negedge clk);
    chk(tag, 32'(starts >= target), 1);
  endtask

  logic [15:0] d;
  int          b;
  int          s0;

  initial begin
    rst = 1; cyc = 0; stb = 0; we = 0; adr = '0; wdat = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_dat", 32'(rdat), 0);
    chk("rst_mux", 32'(mux_sel), 0);
    chk("rst_start", 32'(adc_start), 0);
    chk("rst_strb", 32'(adc_strb), 0);
    chk("rst_result", 32'(adc_result), 0);
    chk("rst_channel", 32'(adc_channel), 0);

    wb_rd(16'd3, d); chk("rd_settle_rst", 32'(d), 16);
    wb_rd(16'd7, d); chk("rd_unmapped", 32'(d), 0);
    wb_rd(16'd4, d); chk("rd_status_rst", 32'(d), 32'h1F00);
    wb_rd(16'd1, d); chk("rd_mask_lo_rst", 32'(d), 32'hFFFF);
    wb_rd(16'd0, d); chk("rd_ctrl_rst", 32'(d), 0);

    // Back-to-back strobe held for two cycles: one ack only.
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 16'd3;
    @(negedge clk);
    chk("b2b_ack", 32'(ack), 1);
    chk("b2b_data", 32'(rdat), 16);
    @(negedge clk);
    chk("b2b_no_second_ack", 32'(ack), 0);
    cyc = 0; stb = 0;
    @(negedge clk);
    chk("b2b_idle", 32'(ack), 0);

    // Sweep over ch0 and ch2.
    b = ch_q.size();
    wb_wr(16'd1, 16'h0005);
    wb_wr(16'd2, 16'h0000);
    wb_wr(16'd3, 16'd2);
    wb_wr(16'd0, 16'd1);
    wait_strb(b + 4, 300, "t1_strobe_count");
    for (int k = 0; k < 4; k++) begin
      if (ch_q.size() > b + k) begin
        chk("t1_channel", 32'(ch_q[b+k]), (k % 2) ? 2 : 0);
        chk("t1_result", 32'(res_q[b+k]), (k % 2) ? 32'h020 : 32'h000);
      end
    end
    if (gap_q.size() > 0) chk("t1_strobe_to_start", 32'(gap_q[0]), 4);
    repeat (3) @(negedge clk);
    chk("t1_result_hold", 32'(adc_result), 32'h020);
    chk("t1_channel_hold", 32'(adc_channel), 2);

    // ch0 and ch31: wrap-around order.
    wb_wr(16'd0, 16'd0);
    wb_wr(16'd1, 16'h0001);
    wb_wr(16'd2, 16'h8000);
    b = ch_q.size();
    wb_wr(16'd0, 16'd1);
    wait_strb(b + 4, 300, "t2_strobe_count");
    for (int k = 0; k < 4; k++) begin
      if (ch_q.size() > b + k) begin
        chk("t2_channel", 32'(ch_q[b+k]), (k % 2) ? 31 : 0);
        chk("t2_result", 32'(res_q[b+k]), (k % 2) ? 32'h1F0 : 32'h000);
      end
    end
    chk("t2_strobe_width", 32'(dbl), 0);

    // ch3 never answers: abandoned, counted, no strobe for it.
    wb_wr(16'd0, 16'd0);
    wb_wr(16'd1, 16'h000C);
    wb_wr(16'd2, 16'h0000);
    dead_ch = 3;
    b = ch_q.size();
    wb_wr(16'd0, 16'd1);
    wait_strb(b + 2, 1500, "t3_strobe_count");
    for (int k = 0; k < 2; k++)
      if (ch_q.size() > b + k) chk("t3_channel", 32'(ch_q[b+k]), 2);
    wb_rd(16'd5, d); chk("t3_errcnt", 32'(d), 1);
    wb_wr(16'd5, 16'hABCD);
    wb_rd(16'd5, d); chk("t3_errcnt_clear", 32'(d), 0);
    wb_wr(16'd0, 16'd0);
    dead_ch = -1;

    // Disable mid-conversion: the late done produces nothing.
    wb_wr(16'd1, 16'h0001);
    s0 = starts;
    b  = ch_q.size();
    wb_wr(16'd0, 16'd1);
    wait_start(s0 + 1, 100, "t4_start_seen");
    repeat (2) @(negedge clk);
    wb_wr(16'd0, 16'd0);
    repeat (20) @(negedge clk);
    chk("t4_no_strobe", 32'(ch_q.size()), 32'(b));
    chk("t4_mux_quiet", 32'(mux_sel), 0);
    wb_rd(16'd4, d); chk("t4_status_idle", 32'(d), 32'h1F00);
    wb_wr(16'd1, 16'h0005);
    b = ch_q.size();
    wb_wr(16'd0, 16'd1);
    wait_strb(b + 1, 100, "t4_restart_count");
    if (ch_q.size() > b) chk("t4_restart_ch", 32'(ch_q[b]), 0);

    // Empty mask while enabled: stall in selection.
    wb_wr(16'd1, 16'h0000);
    repeat (40) @(negedge clk);
    s0 = starts;
    b  = ch_q.size();
    repeat (10000) @(negedge clk);
    chk("t5_no_start", 32'(starts), 32'(s0));
    chk("t5_no_strobe", 32'(ch_q.size()), 32'(b));
    wb_rd(16'd4, d); chk("t5_busy", 32'(d[0]), 1);
    wb_wr(16'd1, 16'h0001);
    wait_strb(b + 2, 200, "t5_resume_count");
    for (int k = 0; k < 2; k++)
      if (ch_q.size() > b + k) chk("t5_resume_ch", 32'(ch_q[b+k]), 0);

    // Reset mid-conversion after a ch1 result.
    wb_wr(16'd1, 16'h0002);
    b = ch_q.size();
    wait_strb(b + 2, 200, "t6_ch1_count");
    if (ch_q.size() > b + 1) chk("t6_ch1_result", 32'(res_q[b+1]), 32'h010);
    s0 = starts;
    wait_start(s0 + 1, 100, "t6_start_seen");
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("t6_start_low", 32'(adc_start), 0);
    chk("t6_result_rst", 32'(adc_result), 0);
    chk("t6_channel_rst", 32'(adc_channel), 0);
    b = ch_q.size();
    repeat (20) @(negedge clk);
    chk("t6_no_strobe", 32'(ch_q.size()), 32'(b));
    wb_rd(16'd0, d); chk("t6_ctrl_rst", 32'(d), 0);
    wb_rd(16'd3, d); chk("t6_settle_rst", 32'(d), 16);
    wb_rd(16'd2, d); chk("t6_mask_hi_rst", 32'(d), 32'hFFFF);
    wb_rd(16'd4, d); chk("t6_status_rst", 32'(d), 32'h1F00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
